// File: rtl/lift_floor_counter_pkg.sv
// Shared lift types: floor one-hot constants, motion state encoding, one-hot check.
// Latency: none (package only).
// Backpressure: not applicable.
package lift_pkg;

    localparam logic [2:0] FLOOR_0 = 3'b001;
    localparam logic [2:0] FLOOR_1 = 3'b010;
    localparam logic [2:0] FLOOR_2 = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        ARRIVE = 2'd2,
        DOOR   = 2'd3
    } state_t;

    // True only for the three legal floor codes; also used by the direction register.
    function automatic logic is_onehot(input logic [2:0] v);
        return (v == FLOOR_0) || (v == FLOOR_1) || (v == FLOOR_2);
    endfunction

endpackage

// File: rtl/lift_floor_counter_if.sv
// Request/position bundle between the lift controller front end and the motion stage.
// Latency: none (wiring only).
// Backpressure: requester must hold off while req_ready is low; requests are not queued.
interface lift_floor_counter_if;
    logic       req_valid;
    logic [2:0] req_floor;
    logic       req_ready;
    logic [2:0] count_out;
    logic       start;
    logic       arrived;
    logic       door_open;

    modport master (
        output req_valid, req_floor,
        input  req_ready, count_out, start, arrived, door_open
    );

    modport slave (
        input  req_valid, req_floor,
        output req_ready, count_out, start, arrived, door_open
    );
endinterface

// File: rtl/lift_floor_counter.sv
// Motion stage: steps the cabin one floor per TRAVEL_CYCLES toward a one-hot target, then door dwell.
// Latency: n-floor trip returns to idle n*TRAVEL_CYCLES+1+DOOR_CYCLES edges after acceptance.
// Backpressure: req_ready high only in IDLE; requests seen in any other state are dropped.
module lift_floor_counter
    import lift_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lift_floor_counter_if.slave   bus
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    target_q, target_d;
    logic [2:0]    count_q, count_d;
    logic [2:0]    pos;
    logic          start_q, start_d;
    logic          arrived_q, arrived_d;
    logic          door_q, door_d;
    logic          ready_q, ready_d;

    // Next state, shared timer, position step and registered-output decode.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        target_d = target_q;
        // A corrupted position is pulled back to F0 before anything else uses it.
        pos      = is_onehot(count_q) ? count_q : FLOOR_0;
        count_d  = pos;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && is_onehot(bus.req_floor)) begin
                    timer_d = '0;
                    if (bus.req_floor == pos) begin
                        state_d = DOOR;
                    end else begin
                        target_d = bus.req_floor;
                        state_d  = MOVE;
                    end
                end
            end
            MOVE: begin
                if (timer_q == TRAVEL_LAST) begin
                    timer_d = '0;
                    // Saturating one-floor step; never wraps past F2 or below F0.
                    if (target_q > pos && pos != FLOOR_2) begin
                        count_d = pos << 1;
                    end else if (target_q < pos && pos != FLOOR_0) begin
                        count_d = pos >> 1;
                    end
                    if (count_d == target_q) begin
                        state_d = ARRIVE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ARRIVE: begin
                timer_d = '0;
                state_d = DOOR;
            end
            DOOR: begin
                if (timer_q == DOOR_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are valid right after the edge.
        start_d   = (state_d == MOVE) || (state_d == ARRIVE);
        arrived_d = (state_d == ARRIVE);
        door_d    = (state_d == DOOR);
        ready_d   = (state_d == IDLE);
    end

    // State, timer, target and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            target_q  <= FLOOR_0;
            count_q   <= FLOOR_0;
            start_q   <= 1'b0;
            arrived_q <= 1'b0;
            door_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            target_q  <= target_d;
            count_q   <= count_d;
            start_q   <= start_d;
            arrived_q <= arrived_d;
            door_q    <= door_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.count_out = count_q;
    assign bus.start     = start_q;
    assign bus.arrived   = arrived_q;
    assign bus.door_open = door_q;
    assign bus.req_ready = ready_q;

endmodule

// File: tb/tb_lift_floor_counter.sv
// Self-checking bench for lift_floor_counter: directed trips, vector table, random vs trip-timeline model.
// Latency: n/a.
// Backpressure: requests are driven regardless of req_ready to exercise dropping.
module tb_lift_floor_counter;

    localparam int T = 4;
    localparam int D = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lift_floor_counter_if bus();

    lift_floor_counter #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [2:0] req;
        bit         accept;
        int         cycles;
        logic [2:0] final_floor;
    } vec_t;

    vec_t vecs [8];

    // Trip-timeline reference: position as floor index, time since acceptance.
    int model_cur  = 0;
    int model_src  = 0;
    int model_dst  = 0;
    int model_m    = 0;
    bit model_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed observation: {count_out, start, arrived, door_open, req_ready}
    function automatic logic [6:0] outs();
        return {bus.count_out, bus.start, bus.arrived, bus.door_open, bus.req_ready};
    endfunction

    task automatic request(input logic [2:0] f);
        bus.req_valid = 1'b1;
        bus.req_floor = f;
        tick();
        bus.req_valid = 1'b0;
        bus.req_floor = 3'b000;
    endtask

    function automatic int fidx(input logic [2:0] f);
        case (f)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] foh(input int idx);
        logic [2:0] one;
        one = 3'b001;
        return one << idx;
    endfunction

    function automatic int trip_len(input int src, input int dst);
        int n;
        n = (dst > src) ? dst - src : src - dst;
        return (n == 0) ? D : n * T + 1 + D;
    endfunction

    task automatic model_edge(input bit v, input logic [2:0] f, input bit r);
        if (!r) begin
            model_cur  = 0;
            model_busy = 1'b0;
        end else if (!model_busy) begin
            if (v && fidx(f) >= 0) begin
                model_src  = model_cur;
                model_dst  = fidx(f);
                model_m    = 0;
                model_busy = 1'b1;
            end
        end else begin
            model_m++;
            if (model_m >= trip_len(model_src, model_dst)) begin
                model_busy = 1'b0;
                model_cur  = model_dst;
            end
        end
    endtask

    function automatic logic [6:0] model_exp();
        int n;
        int dir;
        if (!model_busy) return {foh(model_cur), 4'b0001};
        n   = (model_dst > model_src) ? model_dst - model_src : model_src - model_dst;
        dir = (model_dst > model_src) ? 1 : -1;
        if (n == 0)          return {foh(model_src), 4'b0010};
        if (model_m < n * T) return {foh(model_src + dir * (model_m / T)), 4'b1000};
        if (model_m == n * T) return {foh(model_dst), 4'b1100};
        return {foh(model_dst), 4'b0010};
    endfunction

    initial begin
        int cnt;
        bit v;
        bit r;
        logic [2:0] f;

        vecs[0] = '{3'b011, 1'b0, 0,  3'b001};
        vecs[1] = '{3'b000, 1'b0, 0,  3'b001};
        vecs[2] = '{3'b100, 1'b1, 12, 3'b100};
        vecs[3] = '{3'b100, 1'b1, 3,  3'b100};
        vecs[4] = '{3'b001, 1'b1, 12, 3'b001};
        vecs[5] = '{3'b010, 1'b1, 8,  3'b010};
        vecs[6] = '{3'b111, 1'b0, 0,  3'b010};
        vecs[7] = '{3'b001, 1'b1, 8,  3'b001};

        bus.req_valid = 1'b0;
        bus.req_floor = 3'b000;

        // Reset held for two edges
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_count", bus.count_out, 3'b001);
        chk("reset_start", bus.start, 1'b0);
        chk("reset_arrived", bus.arrived, 1'b0);
        chk("reset_door", bus.door_open, 1'b0);
        chk("reset_ready", bus.req_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // Trip up F0 -> F2
        request(3'b100);
        chk("up_k0", outs(), {3'b001, 4'b1000});
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3)  chk("up_k3",  outs(), {3'b001, 4'b1000});
            if (k == 4)  chk("up_k4",  outs(), {3'b010, 4'b1000});
            if (k == 7)  chk("up_k7",  outs(), {3'b010, 4'b1000});
            if (k == 8)  chk("up_k8",  outs(), {3'b100, 4'b1100});
            if (k == 9)  chk("up_k9",  outs(), {3'b100, 4'b0010});
            if (k == 11) chk("up_k11", outs(), {3'b100, 4'b0010});
            if (k == 12) chk("up_k12", outs(), {3'b100, 4'b0001});
        end

        // Trip down F2 -> F0 with a request injected mid-move
        request(3'b001);
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                bus.req_valid = 1'b1;
                bus.req_floor = 3'b010;
            end
            tick();
            if (k == 3) begin
                bus.req_valid = 1'b0;
                bus.req_floor = 3'b000;
                chk("dn_k3", outs(), {3'b100, 4'b1000});
            end
            if (k == 4)  chk("dn_k4",  outs(), {3'b010, 4'b1000});
            if (k == 8)  chk("dn_k8",  outs(), {3'b001, 4'b1100});
            if (k == 10) chk("dn_k10", outs(), {3'b001, 4'b0010});
            if (k == 12) chk("dn_k12", outs(), {3'b001, 4'b0001});
        end
        tick();
        chk("dn_not_queued", outs(), {3'b001, 4'b0001});

        // Same-floor request
        request(3'b001);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) tick();
            if (k < 3) chk("same_dwell", outs(), {3'b001, 4'b0010});
            else       chk("same_idle",  outs(), {3'b001, 4'b0001});
        end

        // Non-one-hot requests in IDLE
        request(3'b011);
        chk("bad_011", outs(), {3'b001, 4'b0001});
        request(3'b000);
        chk("bad_000", outs(), {3'b001, 4'b0001});

        // Vector table of back-to-back requests from F0
        for (int i = 0; i < 8; i++) begin
            request(vecs[i].req);
            chk("vec_ready", bus.req_ready, !vecs[i].accept);
            cnt = 0;
            if (vecs[i].accept) begin
                while (!bus.req_ready && cnt < 100) begin
                    tick();
                    cnt++;
                end
            end
            chk("vec_cycles", cnt, vecs[i].cycles);
            chk("vec_floor", bus.count_out, vecs[i].final_floor);
        end

        // Reset in the middle of a trip
        request(3'b100);
        repeat (4) tick();
        chk("mid_at_f1", bus.count_out, 3'b010);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_reset", outs(), {3'b001, 4'b0001});
        rst_n = 1'b1;

        // Random stimulus against the trip-timeline model
        rst_n = 1'b0;
        tick();
        model_edge(1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(2) == 0);
            f = 3'($urandom_range(7));
            r = ($urandom_range(199) != 0);
            bus.req_valid = v;
            bus.req_floor = f;
            rst_n         = r;
            tick();
            model_edge(v, f, r);
            chk("rand", outs(), model_exp());
        end
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lift_floor_counter.md
# lift_floor_counter

Motion stage of the lift controller. It accepts a one-hot floor request, steps the cabin position one floor at a time at a fixed travel rate, runs a door-open dwell on arrival, and then returns to idle. It drives `count_out` and `start` into the downstream floor/direction register, which derives `floor_state` and `direction` from them.

## Interface
- `TRAVEL_CYCLES`, default 4: clock cycles per one-floor step; must be ≥1.
- `DOOR_CYCLES`, default 3: clock cycles the door stays open on arrival; must be ≥1.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  request strobe
- `req_floor`  in  3  requested floor, one-hot (001 = F0, 010 = F1, 100 = F2)
- `req_ready`  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready`
- `count_out`  out  3  current cabin floor, one-hot
- `start`  out  1  cabin in motion (MOVE or ARRIVE)
- `arrived`  out  1  one-cycle pulse on reaching the target after travel
- `door_open`  out  1  high during the door dwell

## Operation
- All outputs are registered. Reset values: `count_out`=001, `start`=0, `arrived`=0, `door_open`=0, `req_ready`=1, state IDLE, timer 0, target 001.
- States:
  - **IDLE:** waits for a request.
    - Valid one-hot request ≠ `count_out`: latch the target, clear the timer, go to MOVE.
    - Valid one-hot request = `count_out`: go straight to DOOR; no `arrived` pulse, no `start`.
    - Non-one-hot `req_floor` (000, 011, 101, 110, 111): dropped silently and the block stays in IDLE.
  - **MOVE:** `start`=1. The timer counts 0..TRAVEL_CYCLES-1.
    - At terminal count, `count_out` shifts one step toward the target: left shift if target > current, right shift if lower. The timer then clears.
    - If the new `count_out` equals the target, go to ARRIVE on the same edge.
  - **ARRIVE:** exactly 1 cycle with `start`=1 and `arrived`=1. Then go to DOOR with the timer cleared.
  - **DOOR:** `start`=0, `door_open`=1 for DOOR_CYCLES cycles, then IDLE.
- `start` is still high on the cycle in which `count_out` takes its final value. This lets the downstream stage sample the last floor change with `start` asserted.
- `count_out` is always one-hot. It never wraps: F2 never shifts up and F0 never shifts down. Any illegal internal value forces 001 on the next edge.
- Requests outside IDLE are ignored and never queued, because `req_ready`=0 in those states.
- Reset has priority over every transition. Asserting `rst_n`=0 mid-MOVE or mid-DOOR returns all outputs to their reset values at the next edge. The position is lost and the cabin reports F0.

## Timing
- A request accepted at edge E0 puts the block in MOVE from E0, so `start`=1 in the cycle after E0.
- The n-th floor change happens at edge E0 + n·TRAVEL_CYCLES.
- For a trip of n floors:
  - ARRIVE state entered at E0 + n·TRAVEL_CYCLES.
  - `arrived` high for one cycle after that edge.
  - DOOR entered at E0 + n·TRAVEL_CYCLES + 1.
  - IDLE (`req_ready`=1) at E0 + n·TRAVEL_CYCLES + 1 + DOOR_CYCLES.
- Same-floor request accepted at E0: DOOR from E0, IDLE at E0 + DOOR_CYCLES.
- Timer width is $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)+1). One shared timer serves MOVE and DOOR.

## Structure
- `lift_pkg` holds:
  - floor constants FLOOR_0=3'b001, FLOOR_1=3'b010, FLOOR_2=3'b100;
  - the state encoding (IDLE, MOVE, ARRIVE, DOOR);
  - a one-hot-check function, shared with the direction register.
- Single module; no sub-module. The shared timer is inline.

## Test plan
Run with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
- **Reset:** hold `rst_n`=0 for 2 edges → `count_out`=001, `start`=0, `arrived`=0, `door_open`=0, `req_ready`=1.
- **Trip up F0→F2:** request 100 accepted at E0 →
  - `count_out`=010 at E0+4 and 100 at E0+8;
  - `arrived` pulse in the cycle after E0+8 with `start`=1;
  - `door_open` high from E0+9 to E0+12;
  - `req_ready`=1 at E0+12.
- **Trip down F2→F0:** request 001 → `count_out` goes 100→010→001, 4 cycles per step, then `arrived` and a 3-cycle door dwell.
- **Same floor:** request equal to `count_out` → `start` stays 0, no `arrived`, `door_open` high 3 cycles, `count_out` unchanged.
- **Bad or busy request:** `req_floor`=011 or 000 in IDLE → no state change. Valid request during MOVE → ignored, and the original trip completes unchanged.
- **Reset mid-trip:** `rst_n`=0 two cycles after `count_out` reaches 010 → next edge `count_out`=001, `start`=0, `req_ready`=1.
